// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams field bundles in, writes encoded MIPS words to instruction memory
// Illegal kind/ALUCode pairs write a NOP and raise the sticky err flag.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_alu,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_count
);

  localparam logic [2:0] K_R3 = 3'd0, K_SHIFT = 3'd1, K_IMM = 3'd2, K_LW = 3'd3,
                         K_SW = 3'd4, K_BRANCH = 3'd5, K_J = 3'd6, K_JR = 3'd7;

  // Pipeline ALUCode values
  localparam logic [4:0] A_ADD  = 5'd0,  A_AND  = 5'd1,  A_XOR  = 5'd2,  A_OR   = 5'd3,
                         A_NOR  = 5'd4,  A_SUB  = 5'd5,  A_ANDI = 5'd6,  A_XORI = 5'd7,
                         A_ORI  = 5'd8,  A_JR   = 5'd9,  A_BEQ  = 5'd10, A_BNE  = 5'd11,
                         A_BGEZ = 5'd12, A_BGTZ = 5'd13, A_BLEZ = 5'd14, A_BLTZ = 5'd15,
                         A_SLL  = 5'd16, A_SRL  = 5'd17, A_SRA  = 5'd18, A_SLT  = 5'd19,
                         A_SLTU = 5'd20;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_addr;
  logic        w_accept;
  logic        w_illegal;
  logic [31:0] w_word;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_last_word;

  assign w_accept    = in_valid & in_ready;
  assign w_last_word = in_last | (word_count == 9'd255);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_accept && w_last_word) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_RUN);
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
  end

  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    w_op      = 6'h00;
    w_funct   = 6'h00;
    case (in_kind)
      K_R3: begin
        case (in_alu)
          A_ADD:   w_funct = 6'b100000;
          A_AND:   w_funct = 6'b100100;
          A_XOR:   w_funct = 6'b100110;
          A_OR:    w_funct = 6'b100101;
          A_NOR:   w_funct = 6'b100111;
          A_SUB:   w_funct = 6'b100010;
          A_SLT:   w_funct = 6'b101010;
          A_SLTU:  w_funct = 6'b101011;
          A_SLL:   w_funct = 6'b000100;
          A_SRL:   w_funct = 6'b000110;
          A_SRA:   w_funct = 6'b000111;
          default: w_illegal = 1'b1;
        endcase
        w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, w_funct};
      end
      K_SHIFT: begin
        case (in_alu)
          A_SLL:   w_funct = 6'b000000;
          A_SRL:   w_funct = 6'b000010;
          A_SRA:   w_funct = 6'b000011;
          default: w_illegal = 1'b1;
        endcase
        w_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, w_funct};
      end
      K_IMM: begin
        case (in_alu)
          A_ADD:          w_op = 6'b001000;
          A_AND, A_ANDI:  w_op = 6'b001100;
          A_XOR, A_XORI:  w_op = 6'b001110;
          A_OR, A_ORI:    w_op = 6'b001101;
          A_SLT:          w_op = 6'b001010;
          A_SLTU:         w_op = 6'b001011;
          default:        w_illegal = 1'b1;
        endcase
        w_word = {w_op, in_rs, in_rt, in_imm};
      end
      K_LW, K_SW: begin
        w_illegal = (in_alu != A_ADD);
        w_op      = (in_kind == K_LW) ? 6'b100011 : 6'b101011;
        w_word    = {w_op, in_rs, in_rt, in_imm};
      end
      K_BRANCH: begin
        case (in_alu)
          A_BEQ:   w_word = {6'b000100, in_rs, in_rt, in_imm};
          A_BNE:   w_word = {6'b000101, in_rs, in_rt, in_imm};
          A_BGEZ:  w_word = {6'b000001, in_rs, 5'b00001, in_imm};
          A_BLTZ:  w_word = {6'b000001, in_rs, 5'b00000, in_imm};
          A_BGTZ:  w_word = {6'b000111, in_rs, 5'b00000, in_imm};
          A_BLEZ:  w_word = {6'b000110, in_rs, 5'b00000, in_imm};
          default: w_illegal = 1'b1;
        endcase
      end
      K_J: w_word = {6'b000010, in_target};
      K_JR: begin
        w_illegal = (in_alu != A_JR);
        w_word    = {6'b000000, in_rs, 15'h0000, 6'b001000};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // word_count moves on the same edge that raises imem_we, so it always equals words written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= 8'h00;
      imem_wdata <= 32'h0;
      r_addr     <= 8'h00;
      word_count <= 9'd0;
      err        <= 1'b0;
    end else begin
      imem_we <= w_accept;
      if (r_state == S_IDLE && start) begin
        r_addr     <= base_addr;
        word_count <= 9'd0;
        err        <= 1'b0;
      end
      if (w_accept) begin
        imem_addr  <= r_addr;
        imem_wdata <= w_illegal ? 32'h0 : w_word;
        r_addr     <= r_addr + 8'd1;
        word_count <= word_count + 9'd1;
        if (w_illegal || (word_count == 9'd255 && !in_last)) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed-vector bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_alu;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [8:0]  word_count;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [4:0] A_ADD = 5'd0, A_AND = 5'd1, A_OR = 5'd3, A_SUB = 5'd5, A_JR = 5'd9,
                         A_BEQ = 5'd10, A_BGEZ = 5'd12, A_BGTZ = 5'd13, A_SLL = 5'd16;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_kind(in_kind), .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [2:0] k, input logic [4:0] a, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    in_valid  = 1'b1;
    in_kind   = k;
    in_alu    = a;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic begin_session(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
    start     = 1'b0;
    base_addr = 8'hAA;
  endtask

  task automatic check_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    check_vec({tag, "_we"}, {31'h0, imem_we}, 32'h1);
    check_vec({tag, "_addr"}, {24'h0, imem_addr}, {24'h0, addr});
    check_vec({tag, "_data"}, imem_wdata, data);
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_ready"}, {31'h0, in_ready}, 32'h0);
    check_vec({tag, "_we"}, {31'h0, imem_we}, 32'h0);
    check_vec({tag, "_addr"}, {24'h0, imem_addr}, 32'h0);
    check_vec({tag, "_data"}, imem_wdata, 32'h0);
    check_vec({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check_vec({tag, "_done"}, {31'h0, done}, 32'h0);
    check_vec({tag, "_err"}, {31'h0, err}, 32'h0);
    check_vec({tag, "_wc"}, {23'h0, word_count}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0;
    bundle(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    in_valid = 1'b0;
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Session 1: base 0x10, R3 then back-to-back LW / SHIFT / BRANCH
    begin_session(8'h10);
    check_vec("s1_busy", {31'h0, busy}, 32'h1);
    check_vec("s1_ready", {31'h0, in_ready}, 32'h1);
    check_vec("s1_wc0", {23'h0, word_count}, 32'h0);
    bundle(3'd0, A_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    step(); check_write("r3_add", 8'h10, 32'h00221820);
    check_vec("r3_wc", {23'h0, word_count}, 32'h1);
    bundle(3'd3, A_ADD, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
    step(); check_write("lw", 8'h11, 32'h8CA40008);
    bundle(3'd1, A_SLL, 5'd9, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    step(); check_write("sll", 8'h12, 32'h00031100);
    bundle(3'd5, A_BGEZ, 5'd6, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b1);
    step(); check_write("bgez", 8'h13, 32'h04C1FFFE);
    check_vec("s1_done", {31'h0, done}, 32'h1);
    in_valid = 1'b0;
    step();
    check_vec("s1_idle_we", {31'h0, imem_we}, 32'h0);
    check_vec("s1_wc", {23'h0, word_count}, 32'h4);

    // Session 2: J then JR with last, start held high in RUN must be ignored
    begin_session(8'h40);
    start = 1'b1; base_addr = 8'h77;
    bundle(3'd6, A_ADD, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h0000040, 1'b0);
    step(); check_write("j", 8'h40, 32'h08000040);
    bundle(3'd7, A_JR, 5'd31, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 1'b1);
    step(); check_write("jr", 8'h41, 32'h03E00008);
    check_vec("jr_done", {31'h0, done}, 32'h1);
    check_vec("jr_busy", {31'h0, busy}, 32'h1);
    start = 1'b0; in_valid = 1'b0;
    step();
    check_vec("s2_busy", {31'h0, busy}, 32'h0);
    check_vec("s2_done", {31'h0, done}, 32'h0);
    check_vec("s2_wc", {23'h0, word_count}, 32'h2);
    check_vec("s2_err", {31'h0, err}, 32'h0);
    step();
    check_vec("s2_wc_hold", {23'h0, word_count}, 32'h2);

    // Session 3: address wrap 0xFF -> 0x00 -> 0x01, unused fields forced to zero
    begin_session(8'hFF);
    bundle(3'd2, A_OR, 5'd2, 5'd3, 5'd31, 5'd31, 16'h1234, 26'h3FFFFFF, 1'b0);
    step(); check_write("ori", 8'hFF, 32'h34431234);
    bundle(3'd4, A_ADD, 5'd29, 5'd31, 5'd5, 5'd5, 16'h0004, 26'h0, 1'b0);
    step(); check_write("sw", 8'h00, 32'hAFBF0004);
    bundle(3'd0, A_SUB, 5'd4, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h0, 1'b1);
    step(); check_write("r3_sub", 8'h01, 32'h00853022);
    in_valid = 1'b0;
    step();

    // Session 4: illegal SHIFT/and writes NOP and sets err; address still advances
    begin_session(8'h20);
    bundle(3'd1, A_AND, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0);
    step(); check_write("illegal", 8'h20, 32'h00000000);
    check_vec("illegal_err", {31'h0, err}, 32'h1);
    bundle(3'd5, A_BGTZ, 5'd7, 5'd9, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
    step(); check_write("bgtz", 8'h21, 32'h1CE00010);
    bundle(3'd5, A_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b1);
    step(); check_write("beq", 8'h22, 32'h10220003);
    check_vec("sticky_err", {31'h0, err}, 32'h1);
    in_valid = 1'b0;
    step();

    // Session 5: 256 words with no last; err and done on the final write
    begin_session(8'h00);
    check_vec("s5_err_clr", {31'h0, err}, 32'h0);
    bundle(3'd0, A_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      step();
      check_vec("long_addr", {24'h0, imem_addr}, {24'h0, a});
      check_vec("long_we", {31'h0, imem_we}, 32'h1);
      if (i == 254) begin
        check_vec("long_err_254", {31'h0, err}, 32'h0);
        check_vec("long_done_254", {31'h0, done}, 32'h0);
      end
    end
    check_vec("long_done", {31'h0, done}, 32'h1);
    check_vec("long_err", {31'h0, err}, 32'h1);
    check_vec("long_wc", {23'h0, word_count}, 32'd256);
    check_vec("long_ready", {31'h0, in_ready}, 32'h0);
    step();
    check_vec("long_idle_we", {31'h0, imem_we}, 32'h0);
    check_vec("long_idle_busy", {31'h0, busy}, 32'h0);
    in_valid = 1'b0;

    // Session 6: reset mid-RUN with a bundle being accepted
    begin_session(8'h30);
    bundle(3'd0, A_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    step(); check_write("pre_reset", 8'h30, 32'h00221820);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    reset = 1'b0;
    step();
    check_all_zero("post_reset");
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
